// File: rtl/ccd_capture_ctrl.sv
// OV5640 DVP frame-capture controller: arms on start, skips frames, packs byte pairs into 16-bit pixels, checks geometry.
// Optional watchdog enabled by defining CCD_CAPTURE_TIMEOUT_EN.
module ccd_capture_ctrl #(
    parameter int CW          = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic          CCD_PCLK,
    input  logic          CCD_RST,
    input  logic          CCD_VSYNC,
    input  logic          CCD_HSYNC,
    input  logic [7:0]    CCD_DATA,
    input  logic          start,
    input  logic          stop,
    input  logic          continuous,
    input  logic [3:0]    skip_frames,
    input  logic [CW-1:0] cfg_hsize,
    input  logic [CW-1:0] cfg_vsize,
    output logic          busy,
    output logic [15:0]   pix_data,
    output logic          pix_valid,
    output logic          pix_sof,
    output logic          line_end,
    output logic          frame_done,
    output logic          frame_err,
    output logic [3:0]    err_flags,
    output logic [CW-1:0] meas_hsize,
    output logic [CW-1:0] meas_vsize,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ARM,
        S_ACTIVE,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic          vsync_s1, vsync_s2;
    logic          hsync_s1, hsync_s2;
    logic [7:0]    data_s1;
    logic [3:0]    skip_cnt;
    logic          stop_pending;
    logic          phase;
    logic [7:0]    hi_byte, lo_byte;
    logic          pair_ready;
    logic          sof_pending;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] line_cnt;

    logic vs_rise, vs_fall, hs_fall;
    logic capture, line_close, vsize_bad;

    assign vs_rise = vsync_s1 & ~vsync_s2;
    assign vs_fall = ~vsync_s1 & vsync_s2;
    assign hs_fall = ~hsync_s1 & hsync_s2;
    assign busy    = (state != S_IDLE);

    // Bytes seen while VSYNC has already risen belong to blanking and are not packed.
    assign capture    = hsync_s1 & ~vsync_s1;
    assign line_close = (hs_fall | vs_rise) & ((pix_cnt != '0) | phase);
    assign vsize_bad  = (line_cnt != cfg_vsize);

`ifdef CCD_CAPTURE_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wd_cnt;
    logic        wd_run;
    logic        timeout_hit;

    assign wd_run      = (state == S_SYNC) | (state == S_ARM) | (state == S_ACTIVE);
    assign timeout_hit = wd_run & ~(vs_rise | vs_fall) & (wd_cnt == WD_LAST);

    // Held at zero in IDLE, so entering SYNC always starts a fresh count.
    always_ff @(posedge CCD_PCLK) begin
        if (CCD_RST || state == S_IDLE || vs_rise || vs_fall) begin
            wd_cnt <= '0;
        end else if (wd_run) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYC;
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CCD_PCLK) begin
        if (CCD_RST) begin
            state        <= S_IDLE;
            vsync_s1     <= 1'b0;
            vsync_s2     <= 1'b0;
            hsync_s1     <= 1'b0;
            hsync_s2     <= 1'b0;
            data_s1      <= '0;
            skip_cnt     <= '0;
            stop_pending <= 1'b0;
            phase        <= 1'b0;
            hi_byte      <= '0;
            lo_byte      <= '0;
            pair_ready   <= 1'b0;
            sof_pending  <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            pix_data     <= '0;
            pix_valid    <= 1'b0;
            pix_sof      <= 1'b0;
            line_end     <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            err_flags    <= '0;
            meas_hsize   <= '0;
            meas_vsize   <= '0;
            frame_cnt    <= '0;
        end else begin
            vsync_s1 <= CCD_VSYNC;
            hsync_s1 <= CCD_HSYNC;
            data_s1  <= CCD_DATA;
            vsync_s2 <= vsync_s1;
            hsync_s2 <= hsync_s1;

            line_end   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            pair_ready <= 1'b0;
            pix_valid  <= pair_ready;
            pix_sof    <= pair_ready & sof_pending;
            if (pair_ready) begin
                pix_data    <= {hi_byte, lo_byte};
                sof_pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    stop_pending <= 1'b0;
                    if (start) begin
                        skip_cnt <= skip_frames;
                        state    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (stop) state <= S_IDLE;
                    else if (vsync_s1) state <= S_ARM;
                end
                S_ARM: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (vs_fall) begin
                        if (skip_cnt != '0) begin
                            skip_cnt <= skip_cnt - 4'd1;
                            state    <= S_SYNC;
                        end else begin
                            line_cnt    <= '0;
                            pix_cnt     <= '0;
                            phase       <= 1'b0;
                            err_flags   <= '0;
                            sof_pending <= 1'b1;
                            state       <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (stop) stop_pending <= 1'b1;
                    if (capture) begin
                        if (!phase) begin
                            hi_byte <= data_s1;
                            phase   <= 1'b1;
                        end else begin
                            lo_byte    <= data_s1;
                            pair_ready <= 1'b1;
                            phase      <= 1'b0;
                            pix_cnt    <= (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + 1'b1;
                        end
                    end
                    if (line_close) begin
                        line_end   <= 1'b1;
                        meas_hsize <= pix_cnt;
                        if (pix_cnt != cfg_hsize) err_flags[0] <= 1'b1;
                        if (phase) err_flags[2] <= 1'b1;
                        line_cnt <= (line_cnt == CNT_MAX) ? line_cnt : line_cnt + 1'b1;
                        pix_cnt  <= '0;
                        phase    <= 1'b0;
                    end
                    if (vs_rise) state <= S_DONE;
                end
                S_DONE: begin
                    meas_vsize <= line_cnt;
                    if (vsize_bad) err_flags[1] <= 1'b1;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    frame_err  <= (err_flags != '0) | vsize_bad;
                    if (stop) stop_pending <= 1'b1;
                    state <= (continuous && !stop_pending && !stop) ? S_ARM : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (timeout_hit) begin
                err_flags[3] <= 1'b1;
                frame_err    <= 1'b1;
                state        <= S_IDLE;
            end
        end
    end

endmodule
